// File: rtl/buf_addr_pool_if.sv
// Buffer-address pool streams: the issue stream (m_addr_*) carries free
// addresses to the packet writer, and the return stream (s_free_*) carries
// addresses back from the consumer. The master modport is the pool side.
interface buf_addr_pool_if;
  logic [31:0] m_addr_tdata;
  logic        m_addr_tvalid;
  logic        m_addr_tready;
  logic [31:0] s_free_tdata;
  logic        s_free_tvalid;
  logic        s_free_tready;

  modport master (
    output m_addr_tdata,
    output m_addr_tvalid,
    input  m_addr_tready,
    input  s_free_tdata,
    input  s_free_tvalid,
    output s_free_tready
  );

  modport slave (
    input  m_addr_tdata,
    input  m_addr_tvalid,
    output m_addr_tready,
    output s_free_tdata,
    output s_free_tvalid,
    input  s_free_tready
  );
endinterface

// File: rtl/buf_addr_pool.sv
// Free buffer-address pool. After reset the pool fills itself with
// BUF_BASE + i*BUF_STRIDE (one entry per clock), then hands addresses out
// first-word-fall-through on the issue stream and takes them back on the
// return stream. A circular FIFO with read/write pointers and a level counter
// holds the free addresses.
// Optional feature: define BUF_ADDR_POOL_CHECK_EN to validate returned
// addresses (stride alignment and pool range); bad ones are dropped and
// flagged on err_drop. Without it every accepted return is pushed and
// err_drop is held low.
module buf_addr_pool #(
  parameter int unsigned DEPTH      = 64,
  parameter logic [31:0] BUF_BASE   = 32'h1000_0000,
  parameter int unsigned BUF_STRIDE = 2048
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  buf_addr_pool_if.master        addr_bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   init_done,
  output logic                   err_drop
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int STRIDE_W = $clog2(BUF_STRIDE);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [LVL_W-1:0]  level_reg, level_next;

  // Address storage; no reset, contents are only meaningful below level.
  logic [31:0]       mem [DEPTH];
  logic              mem_we;
  logic [31:0]       mem_wdata;

  logic              m_valid_c;
  logic              s_ready_c;
  logic [31:0]       m_data_c;
  logic              pop;
  logic              ret_accept;
  logic              push;
  logic              ret_ok;
  logic [31:0]       init_addr;

  // During the fill the write pointer doubles as the buffer index.
  assign init_addr = BUF_BASE + (32'(wr_ptr_reg) << STRIDE_W);

`ifdef BUF_ADDR_POOL_CHECK_EN
  localparam logic [31:0] ALIGN_MASK = 32'(BUF_STRIDE - 1);
  localparam logic [63:0] POOL_LO    = {32'd0, BUF_BASE};
  localparam logic [63:0] POOL_HI    = POOL_LO + (64'(DEPTH) * 64'(BUF_STRIDE));

  logic [31:0] ret_off;
  logic [63:0] ret_addr_w;
  logic        err_drop_reg;

  // Range compare is done in 64 bits so a pool reaching the top of the
  // 32-bit space cannot wrap its upper bound.
  assign ret_off    = addr_bus.s_free_tdata - BUF_BASE;
  assign ret_addr_w = {32'd0, addr_bus.s_free_tdata};
  assign ret_ok     = ((ret_off & ALIGN_MASK) == 32'd0)
                   && (ret_addr_w >= POOL_LO)
                   && (ret_addr_w <  POOL_HI);

  // One-cycle flag for each accepted return that fails validation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_drop_reg <= 1'b0;
    end else begin
      err_drop_reg <= ret_accept && !ret_ok;
    end
  end

  assign err_drop = err_drop_reg;
`else
  assign ret_ok   = 1'b1;
  assign err_drop = 1'b0;
`endif

  // Next-state, FIFO control and stream outputs for the fill/run machine.
  always_comb begin
    state_next  = state_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    level_next  = level_reg;
    mem_we      = 1'b0;
    mem_wdata   = init_addr;
    m_valid_c   = 1'b0;
    s_ready_c   = 1'b0;
    m_data_c    = 32'd0;
    pop         = 1'b0;
    ret_accept  = 1'b0;
    push        = 1'b0;

    case (state_reg)
      ST_INIT: begin
        // Level reaches DEPTH with the last write; leave on the next cycle.
        if (level_reg == LVL_FULL) begin
          state_next = ST_RUN;
        end else begin
          mem_we      = 1'b1;
          wr_ptr_next = wr_ptr_reg + 1'b1;
          level_next  = level_reg + 1'b1;
        end
      end
      ST_RUN: begin
        m_valid_c  = (level_reg != '0) && enable;
        s_ready_c  = (level_reg != LVL_FULL);
        // Head is shown regardless of enable so a re-enabled offer is unchanged.
        if (level_reg != '0) begin
          m_data_c = mem[rd_ptr_reg];
        end
        pop        = m_valid_c && addr_bus.m_addr_tready;
        ret_accept = addr_bus.s_free_tvalid && s_ready_c;
        push       = ret_accept && ret_ok;
        if (push) begin
          mem_we      = 1'b1;
          mem_wdata   = addr_bus.s_free_tdata;
          wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        if (push && !pop) begin
          level_next = level_reg + 1'b1;
        end else if (pop && !push) begin
          level_next = level_reg - 1'b1;
        end
      end
    endcase
  end

  // State, pointer and level registers; reset discards every held address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_INIT;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      level_reg  <= level_next;
    end
  end

  // FIFO storage write port, shared by the fill and by accepted returns.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_reg] <= mem_wdata;
    end
  end

  assign addr_bus.m_addr_tvalid = m_valid_c;
  assign addr_bus.m_addr_tdata  = m_data_c;
  assign addr_bus.s_free_tready = s_ready_c;
  assign level                  = level_reg;
  assign init_done              = (state_reg == ST_RUN);

endmodule
